regfile_param: RTL

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param_if.sv | 30 +++
 rtl/regfile_param.sv | 118 +++++++++++
 2 files changed

// File: rtl/regfile_param_if.sv
// rtl/regfile_param_if.sv - read, write, issue and status signals of the register file
interface regfile_param_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2
);
  logic [NRP*AW-1:0]   rs_addr;
  logic [NRP*XLEN-1:0] rs_data;
  logic [NRP-1:0]      rs_pending;
  logic                wa_en;
  logic [AW-1:0]       wa_addr;
  logic [XLEN-1:0]     wa_data;
  logic                wb_en;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                iss_en;
  logic [AW-1:0]       iss_rd;
  logic                ready;

  // Master drives addresses, writes and issues; the register file answers.
  modport master (
    output rs_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, iss_en, iss_rd,
    input  rs_data, rs_pending, ready
  );

  modport slave (
    input  rs_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, iss_en, iss_rd,
    output rs_data, rs_pending, ready
  );
endinterface

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - multi-port register file with dual write, bypass, scoreboard and clear sweep
module regfile_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          reset,
  regfile_param_if.slave bus
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);
  localparam logic [AW-1:0] ZERO_ADDR = '0;
  localparam bit            HAS_ZERO  = (ZERO_REG != 0);

  state_t          state;
  logic [AW-1:0]   cnt;
  logic            ready_q;

  logic [XLEN-1:0] mem [NREGS];
  logic [NREGS-1:0] pend;

  logic            sweep;
  logic            run;
  logic            wa_eff;
  logic            wb_eff;
  logic            iss_eff;

  // Reset overrides the registered state so outputs go quiet in the very
  // cycle reset is raised, not one edge later.
  assign sweep = (state == CLEAR) && !reset;
  assign run   = (state == RUN) && !reset;

  // Port B loses to port A on an address collision; register 0 swallows
  // writes and issues when hardwired.
  assign wa_eff  = run && bus.wa_en && !(HAS_ZERO && (bus.wa_addr == ZERO_ADDR));
  assign wb_eff  = run && bus.wb_en && !(HAS_ZERO && (bus.wb_addr == ZERO_ADDR))
                   && !(wa_eff && (bus.wa_addr == bus.wb_addr));
  assign iss_eff = run && bus.iss_en && !(HAS_ZERO && (bus.iss_rd == ZERO_ADDR));

  assign bus.ready = ready_q;

  // Sweep FSM: walk every address once after reset, then serve traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + AW'(1);
          if (cnt == LAST_ADDR) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          state   <= RUN;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= CLEAR;
          cnt     <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage and scoreboard: sweep clears one entry per cycle; in RUN the
  // issue beats a same-cycle write so the new producer stays outstanding.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) begin
      if (sweep && (cnt == AW'(r))) begin
        mem[r]  <= '0;
        pend[r] <= 1'b0;
      end else begin
        if (wa_eff && (bus.wa_addr == AW'(r))) begin
          mem[r] <= bus.wa_data;
        end else if (wb_eff && (bus.wb_addr == AW'(r))) begin
          mem[r] <= bus.wb_data;
        end
        if (iss_eff && (bus.iss_rd == AW'(r))) begin
          pend[r] <= 1'b1;
        end else if ((wa_eff && (bus.wa_addr == AW'(r))) ||
                     (wb_eff && (bus.wb_addr == AW'(r)))) begin
          pend[r] <= 1'b0;
        end
      end
    end
  end

  // Read ports: each is an independent mux with same-cycle write bypass.
  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit_a;
    logic          hit_b;

    assign addr  = bus.rs_addr[i*AW +: AW];
    assign hit_a = wa_eff && (bus.wa_addr == addr);
    assign hit_b = wb_eff && (bus.wb_addr == addr);

    assign bus.rs_data[i*XLEN +: XLEN] =
        !run                            ? '0 :
        hit_a                           ? bus.wa_data :
        hit_b                           ? bus.wb_data :
        (HAS_ZERO && addr == ZERO_ADDR) ? '0 :
                                          mem[addr];

    assign bus.rs_pending[i] = run && pend[addr] && !hit_a && !hit_b;
  end

endmodule
